// File: rtl/id_issue_stage.sv
// Decode-and-issue stage: decodes 32-bit words into EX control fields, holds them in a
// one-entry output register and interlocks RAW hazards against a writeback-cleared scoreboard.
module id_issue_stage #(
  parameter int IMM_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        ex_ready,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        ex_valid,
  output logic [6:0]  alu_sel,
  output logic [4:0]  immed5,
  output logic [31:0] immed32,
  output logic        immed_sel,
  output logic        shift,
  output logic        sh_dir,
  output logic [2:0]  sh_func,
  output logic        PSR_Wen,
  output logic [4:0]  rs_a,
  output logic [4:0]  rs_b,
  output logic [4:0]  rd,
  output logic        rd_wen,
  output logic        illegal
);

  typedef struct packed {
    logic [6:0]  alu_sel;
    logic [4:0]  immed5;
    logic [31:0] immed32;
    logic        immed_sel;
    logic        shift;
    logic        sh_dir;
    logic [2:0]  sh_func;
    logic        psr_wen;
    logic [4:0]  rs_a;
    logic [4:0]  rs_b;
    logic [4:0]  rd;
    logic        rd_wen;
  } ex_ctl_t;

  ex_ctl_t     ctl_q, ctl_d, dec;
  logic        ex_valid_q, ex_valid_d;
  logic [31:0] pending_q, pending_d;
  logic        illegal_q, illegal_d;

  logic             dec_load, dec_illegal, use_a, use_b;
  logic             busy_a, busy_b, hazard, xfer;
  logic [IMM_W-1:0] imm_raw;
  logic [4:0]       src_a, src_b;

  assign imm_raw = {in_instr[17:13], in_instr[IMM_W-6:0]};
  assign src_a   = in_instr[17:13];
  assign src_b   = in_instr[12:8];

  always_comb begin
    dec         = '0;
    dec_load    = 1'b0;
    dec_illegal = 1'b0;
    use_a       = 1'b0;
    use_b       = 1'b0;
    case (in_instr[31:30])
      2'b00: begin
        dec_load    = 1'b1;
        dec.alu_sel = in_instr[29:23];
        dec.rs_a    = src_a;
        use_a       = 1'b1;
      end
      2'b01: begin
        dec_load      = 1'b1;
        dec.alu_sel   = in_instr[29:23];
        dec.immed32   = {{(32-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};
        dec.immed_sel = 1'b1;
      end
      2'b10: begin
        if (in_instr[24:23] != 2'b00) begin
          dec_illegal = 1'b1;
        end else begin
          dec_load    = 1'b1;
          dec.shift   = 1'b1;
          dec.sh_dir  = in_instr[29];
          dec.sh_func = in_instr[28:26];
          if (in_instr[25]) begin
            dec.immed5    = src_a;
            dec.immed_sel = 1'b1;
          end else begin
            // register shift: shamt arrives on srcA, so rs_a is a real read
            dec.rs_a = src_a;
            use_a    = 1'b1;
          end
        end
      end
      default: dec_illegal = (in_instr[29:0] != 30'd0);
    endcase
    if (dec_load) begin
      dec.rd      = in_instr[22:18];
      dec.rs_b    = src_b;
      dec.psr_wen = in_instr[7];
      dec.rd_wen  = (in_instr[22:18] != 5'd0);
      use_b       = 1'b1;
    end
  end

  // A writeback landing this cycle bypasses its own pending bit
  always_comb begin
    busy_a   = use_a && (src_a != 5'd0) && pending_q[src_a] && !(wb_valid && wb_rd == src_a);
    busy_b   = use_b && (src_b != 5'd0) && pending_q[src_b] && !(wb_valid && wb_rd == src_b);
    hazard   = busy_a || busy_b;
    in_ready = !reset && !flush && !hazard && (!ex_valid_q || ex_ready);
    xfer     = in_valid && in_ready;
  end

  always_comb begin
    ctl_d      = ctl_q;
    ex_valid_d = ex_valid_q;
    pending_d  = pending_q;
    illegal_d  = xfer && dec_illegal;
    if (wb_valid)
      pending_d[wb_rd] = 1'b0;
    if (flush && ex_valid_q && ctl_q.rd_wen)
      pending_d[ctl_q.rd] = 1'b0;
    if (xfer && dec_load) begin
      ctl_d      = dec;
      ex_valid_d = 1'b1;
      // applied after the clears so a newer writer of wb_rd stays pending
      if (dec.rd_wen)
        pending_d[dec.rd] = 1'b1;
    end else if (flush || ex_ready) begin
      ex_valid_d = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q      <= '0;
      ex_valid_q <= 1'b0;
      pending_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      ctl_q      <= ctl_d;
      ex_valid_q <= ex_valid_d;
      pending_q  <= pending_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign alu_sel   = ctl_q.alu_sel;
  assign immed5    = ctl_q.immed5;
  assign immed32   = ctl_q.immed32;
  assign immed_sel = ctl_q.immed_sel;
  assign shift     = ctl_q.shift;
  assign sh_dir    = ctl_q.sh_dir;
  assign sh_func   = ctl_q.sh_func;
  assign PSR_Wen   = ctl_q.psr_wen;
  assign rs_a      = ctl_q.rs_a;
  assign rs_b      = ctl_q.rs_b;
  assign rd        = ctl_q.rd;
  assign rd_wen    = ctl_q.rd_wen;
  assign illegal   = illegal_q;

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode-and-issue stage that feeds the EX datapath.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them into EX control fields: alu_sel, immediates, immed_sel, shift controls and PSR_Wen.
- Holds the decoded result in a one-entry output register with its own valid/ready handshake.
- Interlocks read-after-write hazards with a register scoreboard that the writeback stage clears.

Parameters:
- IMM_W, 12, width of the ALU immediate, sign-extended to 32 bits (fixed split: 5 bits from [17:13], IMM_W-5 bits from [IMM_W-6:0]).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction word present.
- in_instr  in  32  instruction word.
- in_ready  out  1  instruction accepted this cycle when high with in_valid.
- ex_ready  in  1  EX can take the held entry.
- flush  in  1  discard held entry and block input this cycle.
- wb_valid  in  1  writeback completing.
- wb_rd  in  5  register being written back.
- ex_valid  out  1  output entry valid.
- alu_sel  out  7  ALU function.
- immed5  out  5  shift amount immediate.
- immed32  out  32  sign-extended immediate; replaces srcA, not srcB.
- immed_sel  out  1  select immediate in place of srcA/srcA[4:0].
- shift  out  1  result taken from shifter.
- sh_dir  out  1  shift direction.
- sh_func  out  3  shifter function.
- PSR_Wen  out  1  update flags.
- rs_a  out  5  source A register (regfile read address).
- rs_b  out  5  source B register.
- rd  out  5  destination register.
- rd_wen  out  1  destination written.
- illegal  out  1  one-cycle pulse when an illegal word is consumed.

Behaviour:
- Encoding:
  - [31:30] class: 00 ALU-reg, 01 ALU-imm, 10 shift, 11 NOP.
  - ALU classes: alu_sel=[29:23].
  - Shift class: sh_dir=[29], sh_func=[28:26], imm-shift=[25]; [24:23] must be 0, otherwise illegal.
  - Common fields: rd=[22:18], rs_a=[17:13], rs_b=[12:8], PSR_Wen=[7].
  - ALU-imm: immed32=sext({[17:13],[6:0]}), immed_sel=1, rs_a unused.
  - Shift-imm: immed5=[17:13], immed_sel=1.
  - Shift-reg: immed_sel=0, shamt comes from srcA.
  - shift=1 only for the shift class. Unused output fields are 0.
  - rd_wen=1 for classes 00/01/10 when rd!=0.
  - Class 11: all-zero word is a NOP; any other word is illegal.
- Sources used for hazard checks:
  - 00: rs_a and rs_b.
  - 01: rs_b.
  - 10 reg: rs_a and rs_b.
  - 10 imm: rs_b.
  - r0 is never hazardous.
- Scoreboard: 32-bit pending mask, bit 0 hardwired 0.
  - hazard = any used source has its pending bit set, unless wb_valid and wb_rd equals that source in the same cycle (same-cycle clear bypass).
- Handshake:
  - in_ready = !reset && !flush && !hazard && (!ex_valid || ex_ready).
  - Transfer = in_valid && in_ready.
- Output register on transfer of a class 00/01/10 word:
  - Loads the decoded fields and sets ex_valid=1.
  - Sets pending[rd] when rd_wen.
- Class 11 words:
  - Consumed by the handshake but never loaded.
  - If ex_ready, ex_valid falls to 0 next cycle.
  - Illegal words pulse illegal=1 on the following cycle.
- No transfer with ex_ready=1: ex_valid goes to 0.
- No transfer with ex_ready=0: held entry is stable, all fields unchanged.
- Latency: accepted word appears on the outputs 1 cycle after transfer. Throughput is 1 per cycle when there are no hazards.
- Scoreboard clear: wb_valid clears pending[wb_rd].
  - Same-cycle set and clear of the same register: the set wins, because the newer writer is pending.
- flush:
  - ex_valid goes to 0 next cycle.
  - If the held entry had rd_wen, its pending bit clears.
  - in_ready=0 during flush.
  - flush overrides ex_ready.
- reset: ex_valid=0, pending=0, illegal=0 and every output field=0 on the next edge. Any in-flight entry is dropped.

Test Plan:
- Reset held 2 cycles, then in_instr=0x008C2280 with ex_ready=1 -> next cycle ex_valid=1, alu_sel=0x01, rd=3, rs_a=1, rs_b=2, PSR_Wen=1, immed_sel=0, rd_wen=1. pending[3] is set.
- in_instr=0x4093E27F -> immed32=0xFFFFFFFF, immed_sel=1, alu_sel=0x01, rd=4, rs_b=2, PSR_Wen=0.
- in_instr=0xAA14E600 -> shift=1, sh_dir=1, sh_func=2, immed5=7, immed_sel=1, rd=5, rs_b=6.
- Issue a write to r3, then a word reading rs_a=3 -> in_ready=0 for as long as no writeback occurs. Pulse wb_valid with wb_rd=3 -> in_ready=1 in that same cycle and the word issues.
- Hold ex_ready=0 with ex_valid=1 and in_valid=1 -> in_ready=0 and outputs stable for 5 cycles. Then assert flush -> ex_valid=0 next cycle and the held rd's pending bit is cleared.
- in_instr=0xC0000001 -> in_ready=1, ex_valid stays 0, illegal pulses 1 for exactly one cycle. in_instr=0x00000000 -> consumed, no illegal pulse.
